// File: rtl/acc_stream_ctrl.sv
// rtl/acc_stream_ctrl.sv - accelerator job controller: SRAM -> core -> SRAM streaming
//
// Purpose: on enable, reads FRAME_LEN samples from the source buffer at RD_BASE,
// streams them to the core through a 2-entry skid FIFO, and writes the core's
// results to the result buffer at WR_BASE. Dropping enable aborts the job at once.
//
// Ports:
//   clk, reset (async, active-low)
//   enable                                    job request, held until both dones
//   rd_en / rd_addr / rd_data                 source SRAM, 1-cycle read latency
//   core_in_data / core_in_valid / core_in_ready     sample stream to the core
//   core_out_data / core_out_valid / core_out_ready  result stream from the core
//   wr_en / wr_addr / wr_data                 result SRAM write port
//   read_done / write_done                    job status
//   cycle_cnt                                 job RUN-cycle count
//
// Optional feature: define ACC_STREAM_CTRL_PERF_CNT_EN to build the cycle_cnt
// counter; otherwise cycle_cnt is tied to 0.

module acc_stream_ctrl #(
  parameter int         FRAME_LEN = 64,
  parameter int         DATA_W    = 32,
  parameter logic [7:0] RD_BASE   = 8'h00,
  parameter logic [7:0] WR_BASE   = 8'h80
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              rd_en,
  output logic [7:0]        rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] core_in_data,
  output logic              core_in_valid,
  input  logic              core_in_ready,
  input  logic [DATA_W-1:0] core_out_data,
  input  logic              core_out_valid,
  output logic              core_out_ready,
  output logic              wr_en,
  output logic [7:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              read_done,
  output logic              write_done,
  output logic [15:0]       cycle_cnt
);

  localparam logic [7:0] LEN  = 8'(FRAME_LEN);
  localparam logic [7:0] LAST = 8'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [7:0]        rcnt;      // reads issued
  logic [7:0]        icnt;      // core_in handshakes
  logic [7:0]        wcnt;      // results written
  logic              inflight;  // a read was issued last cycle; rd_data valid now
  logic [DATA_W-1:0] fifo_mem [2];
  logic              fifo_rd_ptr;
  logic              fifo_wr_ptr;
  logic [1:0]        fifo_count;
  logic              run;
  logic              push;
  logic              pop;

  assign run = (state == RUN);

  // Reads are throttled so that every issued read has a FIFO slot waiting for it.
  assign rd_en = run && (rcnt < LEN) &&
                 (({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2);
  assign rd_addr = rd_en ? (RD_BASE + rcnt) : 8'h00;

  assign push          = inflight;
  assign core_in_valid = run && (fifo_count != 2'd0);
  assign core_in_data  = core_in_valid ? fifo_mem[fifo_rd_ptr] : '0;
  assign pop           = core_in_valid && core_in_ready;

  assign core_out_ready = run && (wcnt < LEN);
  assign wr_en          = core_out_valid && core_out_ready;
  assign wr_addr        = wr_en ? (WR_BASE + wcnt) : 8'h00;
  assign wr_data        = wr_en ? core_out_data : '0;

  // FIFO storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[fifo_wr_ptr] <= rd_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rcnt        <= 8'd0;
      icnt        <= 8'd0;
      wcnt        <= 8'd0;
      inflight    <= 1'b0;
      fifo_rd_ptr <= 1'b0;
      fifo_wr_ptr <= 1'b0;
      fifo_count  <= 2'd0;
      read_done   <= 1'b0;
      write_done  <= 1'b0;
    end else if (!enable) begin
      // Abort from any state: discard everything including the read in flight.
      state       <= IDLE;
      rcnt        <= 8'd0;
      icnt        <= 8'd0;
      wcnt        <= 8'd0;
      inflight    <= 1'b0;
      fifo_rd_ptr <= 1'b0;
      fifo_wr_ptr <= 1'b0;
      fifo_count  <= 2'd0;
      read_done   <= 1'b0;
      write_done  <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (rd_en) begin
        rcnt <= rcnt + 8'd1;
      end
      if (push) begin
        fifo_wr_ptr <= ~fifo_wr_ptr;
      end
      if (pop) begin
        fifo_rd_ptr <= ~fifo_rd_ptr;
        icnt        <= icnt + 8'd1;
        if (icnt == LAST) begin
          read_done <= 1'b1;
        end
      end
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
      if (wr_en) begin
        wcnt <= wcnt + 8'd1;
        if (wcnt == LAST) begin
          write_done <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          state <= RUN;
        end
        RUN: begin
          if (read_done && write_done) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ACC_STREAM_CTRL_PERF_CNT_EN
  logic [15:0] cycle_q;

  // Cleared in IDLE (which covers IDLE->RUN), counts RUN cycles, frozen in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q <= 16'd0;
    end else if (!enable || state == IDLE) begin
      cycle_q <= 16'd0;
    end else if (state == RUN && cycle_q != 16'hFFFF) begin
      cycle_q <= cycle_q + 16'd1;
    end
  end

  assign cycle_cnt = cycle_q;
`else
  assign cycle_cnt = 16'd0;
`endif

endmodule

// File: doc/acc_stream_ctrl.md
ACC_STREAM_CTRL -- requirements
Module: acc_stream_ctrl

Interface
REQ-001 Parameter: FRAME_LEN, default 64, samples per accelerator job (2..255).
REQ-002 Parameter: DATA_W, default 32, sample width.
REQ-003 Parameter: RD_BASE, default 8'h00, source buffer base address.
REQ-004 Parameter: WR_BASE, default 8'h80, result buffer base address.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset  in  1  reset, asynchronous, active-low.
REQ-007 enable  in  1  job request from top-level control logic; held high until both dones seen.
REQ-008 rd_en  out  1  source SRAM read strobe; rd_data valid exactly 1 cycle later.
REQ-009 rd_addr  out  8  source SRAM address.
REQ-010 rd_data  in  DATA_W  source SRAM read data.
REQ-011 core_in_data / core_in_valid  out  DATA_W / 1  sample stream to core; core_in_ready  in  1.
REQ-012 core_out_data / core_out_valid  in  DATA_W / 1  result stream from core; core_out_ready  out  1.
REQ-013 wr_en / wr_addr / wr_data  out  1 / 8 / DATA_W  result SRAM write port.
REQ-014 read_done / write_done  out  1 / 1  job status back to top-level control logic.
REQ-015 cycle_cnt  out  16  job cycle count (see Configuration).

Function
REQ-016 FSM states IDLE, RUN, DONE; IDLE->RUN when enable=1 at clock edge; RUN->DONE when read_done=1 and write_done=1; DONE->IDLE when enable=0.
REQ-017 Any state with enable=0 -> IDLE next edge: read/write counters, FIFO, in-flight read, dones all cleared (abort).
REQ-018 Read counter rcnt (issued reads) 0..FRAME_LEN; rd_addr = RD_BASE + rcnt, 8-bit wrap.
REQ-019 rd_en = (state==RUN) & (rcnt<FRAME_LEN) & (fifo_count + inflight < 2); combinational.
REQ-020 2-entry FIFO captures rd_data the cycle after rd_en; inflight = registered rd_en.
REQ-021 core_in_valid = FIFO non-empty; core_in_data = FIFO head; pop on core_in_valid & core_in_ready.
REQ-022 Simultaneous push and pop: count unchanged, order preserved; FIFO never overflows.
REQ-023 First core_in_valid 2 cycles after enable sampled, given ready memory.
REQ-024 read_done registered: set the cycle after the FRAME_LEN-th core_in handshake; held until IDLE.
REQ-025 core_out_ready = (state==RUN) & (wcnt<FRAME_LEN).
REQ-026 wr_en = core_out_valid & core_out_ready; wr_addr = WR_BASE + wcnt; wr_data = core_out_data; wcnt increments on wr_en.
REQ-027 write_done registered: set the cycle after the FRAME_LEN-th wr_en; held until IDLE.
REQ-028 Result arriving before read_done accepted normally (read and write overlap).
REQ-029 In DONE and IDLE: rd_en=0, core_in_valid=0, core_out_ready=0, wr_en=0.
REQ-030 enable re-asserted in the cycle DONE->IDLE: new job starts one cycle later from IDLE, counters at 0.

Reset
REQ-031 reset=0 forces immediately: state IDLE, rcnt=0, wcnt=0, FIFO empty, inflight=0, read_done=0, write_done=0, cycle_cnt=0.
REQ-032 All outputs 0 during reset; reset mid-job discards all data; no write issued after reset assertion.

Configuration
REQ-033 Macro ACC_STREAM_CTRL_PERF_CNT_EN.
REQ-034 Defined: cycle_cnt clears on IDLE->RUN, increments each RUN cycle, saturates at 16'hFFFF, holds in DONE, clears in IDLE.
REQ-035 Undefined: cycle_cnt tied to 0, no counter flops; all other behaviour identical.

Verification (FRAME_LEN=4 override)
REQ-036 Core always ready, echoes input 1 cycle later; enable=1 -> reads 0x00..0x03, writes 0x80..0x83 with echoed data, read_done then write_done, FSM in DONE.
REQ-037 core_in_ready low 5 cycles mid-job -> rd_en stalls with FIFO count 2, no data lost/reordered, 4 writes complete.
REQ-038 enable dropped after 2 writes -> IDLE next edge, dones 0, no further rd_en/wr_en; re-enable restarts at 0x00/0x80.
REQ-039 reset asserted asynchronously mid-job -> all outputs 0 without clock edge; after release, idle until enable.
REQ-040 Macro defined, no stalls -> cycle_cnt frozen at job RUN length in DONE; macro undefined -> cycle_cnt=0 throughout.
